hack_screen_scan: RTL and testbench
===================================

HACK_SCREEN_SCAN -- requirements
Module: hack_screen_scan

Interface
REQ-001 SHALL expose parameter H_OFFSET, default 64, meaning left border in pixels before the 512-pixel Hack window.
REQ-002 SHALL expose parameter V_OFFSET, default 112, meaning top border in lines before the 256-line Hack window.
REQ-003 SHALL expose port clk, input, 1 bit, meaning the single clock and the 25 MHz pixel clock.
REQ-004 SHALL expose port resetn, input, 1 bit, meaning reset; resetn is synchronous and active-low.
REQ-005 SHALL expose port vaddr, output, 16 bits, meaning the word address driven to the memory video read port.
REQ-006 SHALL expose port vdata, input, 16 bits, meaning the word returned by memory, registered, valid one clock after vaddr is sampled.
REQ-007 SHALL expose port hsync, output, 1 bit, meaning horizontal sync, active-low.
REQ-008 SHALL expose port vsync, output, 1 bit, meaning vertical sync, active-low.
REQ-009 SHALL expose port video_on, output, 1 bit, meaning high during the 640x480 active area.
REQ-010 SHALL expose port pixel, output, 1 bit, meaning 1 = black (Hack "on") and 0 = white.

Function
REQ-011 SHALL run hcount 0..799 and wrap to 0; vcount SHALL advance on each hcount wrap over 0..524 and wrap to 0.
REQ-012 SHALL treat hcount<640 and vcount<480 as active; hsync is low for hcount 656..751 and vsync is low for vcount 490..491.
REQ-013 SHALL define the Hack window as hcount in [H_OFFSET, H_OFFSET+511] and vcount in [V_OFFSET, V_OFFSET+255]; sx=hcount-H_OFFSET and sy=vcount-V_OFFSET.
REQ-014 SHALL fetch word k of row sy from vaddr = 0x4000 + sy*32 + k, with k in 0..31 and arithmetic on 16 bits with no overflow.
REQ-015 SHALL use a fetch state machine with states IDLE, REQ and LOAD: IDLE->REQ two cycles before each 16-pixel word boundary inside the window; REQ drives vaddr; LOAD captures vdata into a prefetch register; LOAD->IDLE.
REQ-016 SHALL transfer the prefetch register into a 16-bit shifter exactly at the boundary cycle; pixel SHALL present shifter bit 0 first (leftmost pixel), then shift right once per clock.
REQ-017 SHALL register hsync, vsync, video_on and pixel, all delayed by the same fixed pipeline latency of 2 clocks from the counters, so that they stay mutually aligned.
REQ-018 SHALL drive pixel=0 outside the Hack window, unless SCAN_BORDER_EN is defined, and always drive it 0 when video_on=0.
REQ-019 SHALL hold vaddr at its last value when idle and SHALL never drive an address outside 0x4000..0x5FFF.
REQ-020 SHALL emit the last word of a row (k=31) fully; the first fetch of the next row SHALL use the new sy with no carry-over of stale data.

Reset
REQ-021 SHALL, while resetn=0 at a clk edge, set hcount=0, vcount=0, the FSM to IDLE, vaddr=0x4000, shifter=0, prefetch=0, hsync=1, vsync=1, video_on=0 and pixel=0.
REQ-022 SHALL, when reset is asserted mid-frame or mid-fetch, abandon the fetch, discard any in-flight vdata, and restart at hcount=0, vcount=0 on the first cycle after release.

Configuration
REQ-023 SHALL, with SCAN_BORDER_EN defined, drive pixel=1 for active pixels outside the Hack window; without it, border pixels SHALL be 0; window pixels are identical in both builds.

Structure
REQ-024 SHALL place the timing constants (800/525, 640/480, sync start/end), SCREEN_BASE=0x4000, WORDS_PER_ROW=32 and the FSM state enum in shared package hack_pkg.
REQ-025 SHALL implement the counters and sync generation in sub-module vga_timing, which exports hcount, vcount, active and the raw syncs.

Verification
REQ-026 Reset check: hold resetn=0 for 3 cycles, then release -> hsync=vsync=1, video_on=0, pixel=0, vaddr=0x4000; the first hsync falling edge occurs 656+2 clocks after release.
REQ-027 Frame timing check: run 2 frames -> exactly 800 clocks per line, 525 lines per frame, 96-clock hsync pulse and 2-line vsync pulse.
REQ-028 Pixel order check: model memory with word 0x4000=0x0001 and word 0x4001=0x8000 -> pixel is 1 at screen x=64, y=112 and at x=64+31, y=112; all other pixels on that line are 0.
REQ-029 Address walk check: observe vaddr over sy=255 -> the sequence 0x5FE0..0x5FFF appears, then no fetch occurs until the next frame starts again at 0x4000.
REQ-030 Reset-mid-fetch check: assert resetn=0 while the FSM is in REQ at sy=10, k=5 -> after release, no pixel from word 0x4145 appears and scanning restarts at hcount=0, vcount=0.
REQ-031 Border build check: build with SCAN_BORDER_EN, memory all zeros -> pixel=1 at x=0..63 and x=576..639 on every active line, and 0 inside the window.

Source files
------------

// File: rtl/hack_pkg.sv
// hack_pkg: shared constants and types for the Hack screen scanner.
//   - VGA 640x480@60 timing constants (800x525 total, sync windows)
//   - Hack screen memory map (SCREEN_BASE, WORDS_PER_ROW, window size)
//   - Fetch FSM state enum and the per-pixel control payload
//   - word_addr(): screen word address for row sy, word k
package hack_pkg;

  localparam int unsigned CNT_W        = 10;
  localparam int unsigned H_TOTAL      = 800;
  localparam int unsigned V_TOTAL      = 525;
  localparam int unsigned H_ACTIVE     = 640;
  localparam int unsigned V_ACTIVE     = 480;
  localparam int unsigned H_SYNC_START = 656;
  localparam int unsigned H_SYNC_END   = 751;
  localparam int unsigned V_SYNC_START = 490;
  localparam int unsigned V_SYNC_END   = 491;

  localparam logic [15:0] SCREEN_BASE   = 16'h4000;
  localparam int unsigned WORDS_PER_ROW = 32;
  localparam int unsigned WIN_W         = 512;
  localparam int unsigned WIN_H         = 256;

  // The IDLE->REQ decision is taken this many pixels before a word boundary,
  // so REQ sits two cycles before it and LOAD one cycle before it.
  localparam int unsigned FETCH_LEAD = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_LOAD = 2'd2
  } fetch_state_e;

  // Per-pixel control bits travelling down the output pipeline.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic active;
    logic win;
  } scan_ctl_t;

  // Word k of Hack row sy; sy<256 and k<32 keep it inside 0x4000..0x5FFF.
  function automatic logic [15:0] word_addr(input logic [7:0] sy, input logic [4:0] k);
    return SCREEN_BASE + 16'(32'(sy) * WORDS_PER_ROW + 32'(k));
  endfunction

endpackage

// File: rtl/vga_timing.sv
// vga_timing: 800x525 raster counters with combinational decodes.
// Ports:
//   clk, resetn      pixel clock, synchronous active-low reset
//   hcount_o         horizontal position 0..799 (registered)
//   vcount_o         line number 0..524 (registered)
//   active_c_o       high inside the 640x480 visible area (decoded)
//   hsync_c_o        raw active-low horizontal sync (decoded)
//   vsync_c_o        raw active-low vertical sync (decoded)
module vga_timing
  import hack_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  output logic [CNT_W-1:0] hcount_o,
  output logic [CNT_W-1:0] vcount_o,
  output logic             active_c_o,
  output logic             hsync_c_o,
  output logic             vsync_c_o
);

  logic [CNT_W-1:0] hcount_q, hcount_d;
  logic [CNT_W-1:0] vcount_q, vcount_d;
  logic [31:0]      h32, v32;

  // Next raster position; vcount steps on each hcount wrap.
  always_comb begin
    hcount_d = hcount_q + CNT_W'(1);
    vcount_d = vcount_q;
    if (hcount_q == CNT_W'(H_TOTAL - 1)) begin
      hcount_d = '0;
      if (vcount_q == CNT_W'(V_TOTAL - 1)) vcount_d = '0;
      else                                 vcount_d = vcount_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hcount_q <= '0;
      vcount_q <= '0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
    end
  end

  assign h32 = 32'(hcount_q);
  assign v32 = 32'(vcount_q);

  assign hcount_o   = hcount_q;
  assign vcount_o   = vcount_q;
  assign active_c_o = (h32 < H_ACTIVE) && (v32 < V_ACTIVE);
  assign hsync_c_o  = !((h32 >= H_SYNC_START) && (h32 <= H_SYNC_END));
  assign vsync_c_o  = !((v32 >= V_SYNC_START) && (v32 <= V_SYNC_END));

endmodule

// File: rtl/hack_screen_scan.sv
// hack_screen_scan: scans the Hack 512x256 screen memory onto 640x480 VGA.
// Ports:
//   clk, resetn  25 MHz pixel clock, synchronous active-low reset
//   vaddr        word address to the memory video port (0x4000..0x5FFF)
//   vdata        memory word, valid one clock after vaddr is sampled
//   hsync, vsync active-low syncs
//   video_on     high in the 640x480 visible area
//   pixel        1 = black (Hack pixel on), 0 = white
// All four video outputs lag the raster counters by two clocks.
// Build option: define SCAN_BORDER_EN to paint visible pixels outside the
// Hack window black; otherwise they are white.
module hack_screen_scan
  import hack_pkg::*;
#(
  parameter int unsigned H_OFFSET = 64,
  parameter int unsigned V_OFFSET = 112
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [15:0] vaddr,
  input  logic [15:0] vdata,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        pixel
);

`ifdef SCAN_BORDER_EN
  localparam logic BORDER_PIX = 1'b1;
`else
  localparam logic BORDER_PIX = 1'b0;
`endif

  logic [CNT_W-1:0] hcount, vcount;
  logic             active_c, hsync_c, vsync_c;

  vga_timing u_timing (
    .clk        (clk),
    .resetn     (resetn),
    .hcount_o   (hcount),
    .vcount_o   (vcount),
    .active_c_o (active_c),
    .hsync_c_o  (hsync_c),
    .vsync_c_o  (vsync_c)
  );

  // Window decode for the current pixel and for the fetch lookahead pixel.
  logic [31:0] h32, v32, ha32;
  logic        row_in_c, win_c, boundary_c, fetch_go_c;
  logic [3:0]  sx_lo_c;
  logic [8:0]  sxa_c;
  logic [7:0]  sy_c;
  logic [15:0] fetch_addr_c;

  always_comb begin
    h32          = 32'(hcount);
    v32          = 32'(vcount);
    ha32         = h32 + FETCH_LEAD;
    row_in_c     = (v32 >= V_OFFSET) && (v32 < V_OFFSET + WIN_H);
    win_c        = row_in_c && (h32 >= H_OFFSET) && (h32 < H_OFFSET + WIN_W);
    sx_lo_c      = 4'(h32 - H_OFFSET);
    sxa_c        = 9'(ha32 - H_OFFSET);
    sy_c         = 8'(v32 - V_OFFSET);
    boundary_c   = win_c && (sx_lo_c == 4'd0);
    fetch_go_c   = row_in_c && (ha32 >= H_OFFSET) && (ha32 < H_OFFSET + WIN_W) &&
                   (sxa_c[3:0] == 4'd0);
    fetch_addr_c = word_addr(sy_c, sxa_c[8:4]);
  end

  // Fetch FSM: REQ presents the address, LOAD captures the returned word.
  fetch_state_e state_q;
  logic [15:0]  vaddr_q;
  logic [15:0]  prefetch_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      vaddr_q    <= SCREEN_BASE;
      prefetch_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fetch_go_c) begin
            state_q <= ST_REQ;
            vaddr_q <= fetch_addr_c;
          end
        end
        ST_REQ:  state_q <= ST_LOAD;
        ST_LOAD: begin
          prefetch_q <= vdata;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Shifter: reload on each 16-pixel boundary, bit 0 is the leftmost pixel.
  logic [15:0] shifter_q;

  always_ff @(posedge clk) begin
    if (!resetn)         shifter_q <= '0;
    else if (boundary_c) shifter_q <= prefetch_q;
    else                 shifter_q <= shifter_q >> 1;
  end

  // Output pipeline: stage 1 aligns control with the shifter, stage 2 drives pins.
  scan_ctl_t ctl_c, ctl1_q;
  logic      hsync_q, vsync_q, video_on_q, pixel_q;
  logic      pixel_d;

  always_comb begin
    ctl_c = '{hsync: hsync_c, vsync: vsync_c, active: active_c, win: win_c};
    pixel_d = 1'b0;
    if (ctl1_q.active) pixel_d = ctl1_q.win ? shifter_q[0] : BORDER_PIX;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ctl1_q     <= '{hsync: 1'b1, vsync: 1'b1, active: 1'b0, win: 1'b0};
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      video_on_q <= 1'b0;
      pixel_q    <= 1'b0;
    end else begin
      ctl1_q     <= ctl_c;
      hsync_q    <= ctl1_q.hsync;
      vsync_q    <= ctl1_q.vsync;
      video_on_q <= ctl1_q.active;
      pixel_q    <= pixel_d;
    end
  end

  assign vaddr    = vaddr_q;
  assign hsync    = hsync_q;
  assign vsync    = vsync_q;
  assign video_on = video_on_q;
  assign pixel    = pixel_q;

endmodule

// File: tb/tb_hack_screen_scan.sv
// tb_hack_screen_scan: self-checking bench for hack_screen_scan.
// A registered memory model answers vaddr; expected outputs come from a
// raster model computed directly from screen coordinates (two-clock lag).
// Uses V_OFFSET=2 so Hack rows are reached within a short run.
module tb_hack_screen_scan;

  localparam int HO        = 64;
  localparam int VO        = 2;
  localparam int RUN_LINES = 40;
  localparam int FAIL_CAP  = 8;
`ifdef SCAN_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] vaddr;
  logic [15:0] vdata;
  logic        hsync, vsync, video_on, pixel;

  logic [15:0] mem [0:8191];
  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  always #5 clk = ~clk;

  // Registered video read port.
  always @(posedge clk)
    vdata <= (vaddr >= 16'h4000 && vaddr <= 16'h5FFF) ? mem[vaddr[12:0]] : 16'hDEAD;

  hack_screen_scan #(.H_OFFSET(HO), .V_OFFSET(VO)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .vaddr    (vaddr),
    .vdata    (vdata),
    .hsync    (hsync),
    .vsync    (vsync),
    .video_on (video_on),
    .pixel    (pixel)
  );

  // Expected {hsync, vsync, video_on, pixel} at cycle c after release.
  function automatic logic [3:0] exp_out(input int c);
    int t, h, v, sx, sy;
    logic hs, vs, act, win, pix;
    logic [15:0] w;
    if (c < 2) return 4'b1100;
    t   = c - 2;
    h   = t % 800;
    v   = (t / 800) % 525;
    hs  = !(h >= 656 && h <= 751);
    vs  = !(v >= 490 && v <= 491);
    act = (h < 640) && (v < 480);
    win = (h >= HO) && (h < HO + 512) && (v >= VO) && (v < VO + 256);
    pix = 1'b0;
    if (act) begin
      if (win) begin
        sx  = h - HO;
        sy  = v - VO;
        w   = mem[13'(sy * 32 + sx / 16)];
        pix = w[4'(sx % 16)];
      end else begin
        pix = BORDER;
      end
    end
    return {hs, vs, act, pix};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic reset_dut();
    resetn = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    cyc = 0;
  endtask

  task automatic fill_mem(input bit rand_fill);
    for (int i = 0; i < 8192; i++) mem[i] = rand_fill ? 16'($urandom) : 16'h0000;
  endtask

  task automatic test_reset();
    int fall;
    fill_mem(1'b0);
    resetn = 1'b0;
    repeat (3) tick();
    total_cnt++; if (vaddr !== 16'h4000) $display("FAIL reset_vaddr: got %h expected 4000", vaddr); else pass_cnt++;
    total_cnt++; if (hsync !== 1'b1) $display("FAIL reset_hsync: got %b expected 1", hsync); else pass_cnt++;
    total_cnt++; if (vsync !== 1'b1) $display("FAIL reset_vsync: got %b expected 1", vsync); else pass_cnt++;
    total_cnt++; if (video_on !== 1'b0) $display("FAIL reset_video_on: got %b expected 0", video_on); else pass_cnt++;
    total_cnt++; if (pixel !== 1'b0) $display("FAIL reset_pixel: got %b expected 0", pixel); else pass_cnt++;
    resetn = 1'b1;
    cyc = 0;
    fall = -1;
    for (int i = 0; i < 2000 && fall < 0; i++) begin
      tick();
      if (hsync === 1'b0) fall = cyc;
    end
    total_cnt++; if (fall != 658) $display("FAIL first_hsync_fall: got %0d expected 658", fall); else pass_cnt++;
  endtask

  task automatic test_line_timing();
    int falls[$];
    int rises[$];
    int von_cnt, first_von, vs_low, d1, d2, pw;
    logic hs_prev;
    fill_mem(1'b1);
    reset_dut();
    von_cnt = 0; first_von = -1; vs_low = 0; hs_prev = 1'b1;
    while (cyc < 3 * 800 + 200) begin
      if (hs_prev && !hsync) falls.push_back(cyc);
      if (!hs_prev && hsync) rises.push_back(cyc);
      hs_prev = hsync;
      if (video_on && cyc < 802) von_cnt++;
      if (video_on && first_von < 0) first_von = cyc;
      if (!vsync) vs_low++;
      tick();
    end
    d1 = (falls.size() >= 2) ? falls[1] - falls[0] : -1;
    d2 = (falls.size() >= 3) ? falls[2] - falls[1] : -1;
    pw = (falls.size() >= 1 && rises.size() >= 1) ? rises[0] - falls[0] : -1;
    total_cnt++; if (falls.size() != 3) $display("FAIL hsync_fall_count: got %0d expected 3", falls.size()); else pass_cnt++;
    total_cnt++; if (d1 != 800) $display("FAIL line_period_1: got %0d expected 800", d1); else pass_cnt++;
    total_cnt++; if (d2 != 800) $display("FAIL line_period_2: got %0d expected 800", d2); else pass_cnt++;
    total_cnt++; if (pw != 96) $display("FAIL hsync_width: got %0d expected 96", pw); else pass_cnt++;
    total_cnt++; if (von_cnt != 640) $display("FAIL video_on_width: got %0d expected 640", von_cnt); else pass_cnt++;
    total_cnt++; if (first_von != 2) $display("FAIL video_on_start: got %0d expected 2", first_von); else pass_cnt++;
    total_cnt++; if (vs_low != 0) $display("FAIL vsync_early: got %0d low cycles expected 0", vs_low); else pass_cnt++;
  endtask

  task automatic test_pixel_order();
    int errs, ones, exp_ones;
    logic e;
    fill_mem(1'b0);
    mem[0] = 16'h0001;
    mem[1] = 16'h8000;
    reset_dut();
    while (cyc < VO * 800 + 2) tick();
    errs = 0; ones = 0;
    exp_ones = BORDER ? 2 + 128 : 2;
    for (int h = 0; h < 800 && errs < FAIL_CAP; h++) begin
      e = (h == HO) || (h == HO + 31) || (BORDER && h < 640 && (h < HO || h >= HO + 512));
      if (pixel === 1'b1) ones++;
      total_cnt++;
      if (pixel !== e) begin
        $display("FAIL pixel_order x=%0d: got %b expected %b", h, pixel, e);
        errs++;
      end else pass_cnt++;
      tick();
    end
    total_cnt++; if (ones != exp_ones) $display("FAIL pixel_order_ones: got %0d expected %0d", ones, exp_ones); else pass_cnt++;
  endtask

  task automatic test_random_scan();
    logic [15:0] log_q[$];
    logic [15:0] exp_q[$];
    logic [15:0] prev;
    logic [3:0]  e, o;
    int errs, n;
    fill_mem(1'b1);
    reset_dut();
    prev = vaddr;
    errs = 0;
    while (cyc <= RUN_LINES * 800 + 1 && errs < FAIL_CAP) begin
      e = exp_out(cyc);
      o = {hsync, vsync, video_on, pixel};
      total_cnt++;
      if (o !== e) begin
        $display("FAIL scan_out cyc=%0d: got %b expected %b", cyc, o, e);
        errs++;
      end else pass_cnt++;
      total_cnt++;
      if (!(vaddr >= 16'h4000 && vaddr <= 16'h5FFF)) begin
        $display("FAIL vaddr_range cyc=%0d: got %h expected 4000..5FFF", cyc, vaddr);
        errs++;
      end else pass_cnt++;
      if (vaddr !== prev) log_q.push_back(vaddr);
      prev = vaddr;
      tick();
    end
    for (int sy = 0; sy < RUN_LINES - VO; sy++)
      for (int k = 0; k < 32; k++) exp_q.push_back(16'(16'h4000 + sy * 32 + k));
    void'(exp_q.pop_front());
    total_cnt++;
    if (log_q.size() != exp_q.size())
      $display("FAIL fetch_count: got %0d expected %0d", log_q.size(), exp_q.size());
    else pass_cnt++;
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    errs = 0;
    for (int i = 0; i < n && errs < FAIL_CAP; i++) begin
      total_cnt++;
      if (log_q[i] !== exp_q[i]) begin
        $display("FAIL fetch_addr #%0d: got %h expected %h", i, log_q[i], exp_q[i]);
        errs++;
      end else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_fetch();
    int found, errs;
    logic [3:0] e, o;
    fill_mem(1'b0);
    mem[10 * 32 + 5] = 16'hFFFF;
    reset_dut();
    found = 0;
    for (int i = 0; i < 20000 && found == 0; i++) begin
      if (vaddr === 16'h4145) found = 1;
      else tick();
    end
    total_cnt++; if (found != 1) $display("FAIL mid_fetch_reach: got %0d expected 1", found); else pass_cnt++;
    resetn = 1'b0;
    repeat (3) tick();
    total_cnt++; if (vaddr !== 16'h4000) $display("FAIL mid_reset_vaddr: got %h expected 4000", vaddr); else pass_cnt++;
    total_cnt++;
    if ({hsync, vsync, video_on, pixel} !== 4'b1100)
      $display("FAIL mid_reset_outs: got %b expected 1100", {hsync, vsync, video_on, pixel});
    else pass_cnt++;
    resetn = 1'b1;
    cyc = 0;
    errs = 0;
    while (cyc <= 4 * 800 + 1 && errs < FAIL_CAP) begin
      e = exp_out(cyc);
      o = {hsync, vsync, video_on, pixel};
      total_cnt++;
      if (o !== e) begin
        $display("FAIL restart_out cyc=%0d: got %b expected %b", cyc, o, e);
        errs++;
      end else pass_cnt++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_line_timing();
    test_pixel_order();
    test_random_scan();
    test_reset_mid_fetch();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
